// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded control and operands, holds on stall, loads bubbles on flush.
// Optional macro ID_EX_WB_BYPASS_EN forwards same-cycle writeback data into the captured operands.
module id_ex_pipe_reg #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            en,
  input  logic            stall,
  input  logic            flush,
  input  logic [31:0]     instr_i,
  input  logic [DW-1:0]   npc_i,
  input  logic [DW-1:0]   rdat1_i,
  input  logic [DW-1:0]   rdat2_i,
  input  logic [DW-1:0]   imm_i,
  input  logic [RW-1:0]   rsel1_i,
  input  logic [RW-1:0]   rsel2_i,
  input  logic [RW-1:0]   wsel_i,
  input  logic            wen_i,
  input  logic [1:0]      alusrc_i,
  input  logic [3:0]      aluop_i,
  input  logic            dren_i,
  input  logic            dwen_i,
  input  logic            memtoreg_i,
  input  logic            halt_i,
  input  logic            wb_wen,
  input  logic [RW-1:0]   wb_wsel,
  input  logic [DW-1:0]   wb_wdat,
  output logic [31:0]     instr_o2,
  output logic [DW-1:0]   npc_o2,
  output logic [DW-1:0]   rdat1_o2,
  output logic [DW-1:0]   rdat2_o2,
  output logic [DW-1:0]   imm_o2,
  output logic [RW-1:0]   rsel1_o2,
  output logic [RW-1:0]   rsel2_o2,
  output logic [RW-1:0]   wsel_o2,
  output logic            wen_o2,
  output logic [1:0]      alusrc_o2,
  output logic [3:0]      aluop_o2,
  output logic            dren_o2,
  output logic            dwen_o2,
  output logic            memtoreg_o2,
  output logic            halt_o2,
  output logic            valid_o2,
  output logic [CNTW-1:0] bubble_cnt
);

  logic [DW-1:0] rdat1_cap;
  logic [DW-1:0] rdat2_cap;

`ifdef ID_EX_WB_BYPASS_EN
  // Register file writes and reads on the same edge, so decode may have read stale data.
  always_comb begin
    rdat1_cap = rdat1_i;
    rdat2_cap = rdat2_i;
    if (wb_wen && (wb_wsel != '0) && (wb_wsel == rsel1_i)) rdat1_cap = wb_wdat;
    if (wb_wen && (wb_wsel != '0) && (wb_wsel == rsel2_i)) rdat2_cap = wb_wdat;
  end
`else
  logic wb_unused;
  assign wb_unused = ^{wb_wen, wb_wsel, wb_wdat};
  assign rdat1_cap = rdat1_i;
  assign rdat2_cap = rdat2_i;
`endif

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      instr_o2    <= '0;
      npc_o2      <= '0;
      rdat1_o2    <= '0;
      rdat2_o2    <= '0;
      imm_o2      <= '0;
      rsel1_o2    <= '0;
      rsel2_o2    <= '0;
      wsel_o2     <= '0;
      wen_o2      <= 1'b0;
      alusrc_o2   <= '0;
      aluop_o2    <= '0;
      dren_o2     <= 1'b0;
      dwen_o2     <= 1'b0;
      memtoreg_o2 <= 1'b0;
      halt_o2     <= 1'b0;
      valid_o2    <= 1'b0;
      if (RST)
        bubble_cnt <= '0;
      else if (bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNTW'(1);
    end else if (en && !stall) begin
      instr_o2    <= instr_i;
      npc_o2      <= npc_i;
      rdat1_o2    <= rdat1_cap;
      rdat2_o2    <= rdat2_cap;
      imm_o2      <= imm_i;
      rsel1_o2    <= rsel1_i;
      rsel2_o2    <= rsel2_i;
      wsel_o2     <= wsel_i;
      // A write to $0 is dropped here so forwarding never matches register 0.
      wen_o2      <= wen_i && (wsel_i != '0);
      alusrc_o2   <= alusrc_i;
      aluop_o2    <= aluop_i;
      dren_o2     <= dren_i;
      dwen_o2     <= dwen_i;
      memtoreg_o2 <= memtoreg_i;
      halt_o2     <= halt_i;
      valid_o2    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: capture, stall, flush/saturation, $0 normalisation, WB bypass, reset.
module tb_id_ex_pipe_reg;

  logic        CLK = 1'b0;
  logic        RST, en, stall, flush;
  logic [31:0] instr_i, npc_i, rdat1_i, rdat2_i, imm_i;
  logic [4:0]  rsel1_i, rsel2_i, wsel_i;
  logic        wen_i, dren_i, dwen_i, memtoreg_i, halt_i;
  logic [1:0]  alusrc_i;
  logic [3:0]  aluop_i;
  logic        wb_wen;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  logic [31:0] instr_o2, npc_o2, rdat1_o2, rdat2_o2, imm_o2;
  logic [4:0]  rsel1_o2, rsel2_o2, wsel_o2;
  logic        wen_o2, dren_o2, dwen_o2, memtoreg_o2, halt_o2, valid_o2;
  logic [1:0]  alusrc_o2;
  logic [3:0]  aluop_o2;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_ex_pipe_reg dut (
    .CLK(CLK), .RST(RST), .en(en), .stall(stall), .flush(flush),
    .instr_i(instr_i), .npc_i(npc_i), .rdat1_i(rdat1_i), .rdat2_i(rdat2_i), .imm_i(imm_i),
    .rsel1_i(rsel1_i), .rsel2_i(rsel2_i), .wsel_i(wsel_i), .wen_i(wen_i),
    .alusrc_i(alusrc_i), .aluop_i(aluop_i), .dren_i(dren_i), .dwen_i(dwen_i),
    .memtoreg_i(memtoreg_i), .halt_i(halt_i),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .instr_o2(instr_o2), .npc_o2(npc_o2), .rdat1_o2(rdat1_o2), .rdat2_o2(rdat2_o2), .imm_o2(imm_o2),
    .rsel1_o2(rsel1_o2), .rsel2_o2(rsel2_o2), .wsel_o2(wsel_o2), .wen_o2(wen_o2),
    .alusrc_o2(alusrc_o2), .aluop_o2(aluop_o2), .dren_o2(dren_o2), .dwen_o2(dwen_o2),
    .memtoreg_o2(memtoreg_o2), .halt_o2(halt_o2), .valid_o2(valid_o2), .bubble_cnt(bubble_cnt)
  );

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef ID_EX_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  initial begin
    RST = 1'b1; en = 1'b0; stall = 1'b0; flush = 1'b0;
    instr_i = 32'h0; npc_i = 32'h0; rdat1_i = 32'h0; rdat2_i = 32'h0; imm_i = 32'h0;
    rsel1_i = 5'd0; rsel2_i = 5'd0; wsel_i = 5'd0; wen_i = 1'b0;
    alusrc_i = 2'd0; aluop_i = 4'd0; dren_i = 1'b0; dwen_i = 1'b0;
    memtoreg_i = 1'b0; halt_i = 1'b0;
    wb_wen = 1'b0; wb_wsel = 5'd0; wb_wdat = 32'h0;
    @(negedge CLK);
    step();
    chk("rst_valid", 64'(valid_o2), 64'd0);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    chk("rst_instr", 64'(instr_o2), 64'd0);
    chk("rst_alusrc", 64'(alusrc_o2), 64'd0);

    // Load word capture
    RST = 1'b0; en = 1'b1;
    instr_i = 32'h8C43_0004; npc_i = 32'h0000_0104; rdat1_i = 32'h11; rdat2_i = 32'h22;
    imm_i = 32'h4; rsel1_i = 5'd2; rsel2_i = 5'd3; wsel_i = 5'd3; wen_i = 1'b1; dren_i = 1'b1;
    alusrc_i = 2'd1; aluop_i = 4'd3; memtoreg_i = 1'b1;
    step();
    chk("cap_instr", 64'(instr_o2), 64'h8C43_0004);
    chk("cap_npc", 64'(npc_o2), 64'h104);
    chk("cap_rsel1", 64'(rsel1_o2), 64'd2);
    chk("cap_rsel2", 64'(rsel2_o2), 64'd3);
    chk("cap_wsel", 64'(wsel_o2), 64'd3);
    chk("cap_wen", 64'(wen_o2), 64'd1);
    chk("cap_dren", 64'(dren_o2), 64'd1);
    chk("cap_alusrc", 64'(alusrc_o2), 64'd1);
    chk("cap_aluop", 64'(aluop_o2), 64'd3);
    chk("cap_memtoreg", 64'(memtoreg_o2), 64'd1);
    chk("cap_valid", 64'(valid_o2), 64'd1);
    chk("cap_bubble", 64'(bubble_cnt), 64'd0);

    // Stall three cycles with changing inputs
    stall = 1'b1; rdat1_i = 32'hDEAD_BEEF; instr_i = 32'h0; wen_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rdat1", 64'(rdat1_o2), 64'h11);
      chk("stall_instr", 64'(instr_o2), 64'h8C43_0004);
      chk("stall_wen", 64'(wen_o2), 64'd1);
    end
    stall = 1'b0; instr_i = 32'h8C43_0004; wen_i = 1'b1;
    step();
    chk("release_rdat1", 64'(rdat1_o2), 64'hDEAD_BEEF);

    // en low also holds
    en = 1'b0; instr_i = 32'h1234_5678;
    step();
    chk("en_hold_instr", 64'(instr_o2), 64'h8C43_0004);
    en = 1'b1;

    // Flush beats stall
    flush = 1'b1; stall = 1'b1;
    step();
    chk("flush_wen", 64'(wen_o2), 64'd0);
    chk("flush_dren", 64'(dren_o2), 64'd0);
    chk("flush_valid", 64'(valid_o2), 64'd0);
    chk("flush_rsel1", 64'(rsel1_o2), 64'd0);
    chk("flush_rdat1", 64'(rdat1_o2), 64'd0);
    chk("flush_bubble", 64'(bubble_cnt), 64'd1);
    stall = 1'b0;
    for (int i = 0; i < 65533; i++) step();
    chk("sat_below", 64'(bubble_cnt), 64'hFFFE);
    step();
    chk("sat_reach", 64'(bubble_cnt), 64'hFFFF);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", 64'(bubble_cnt), 64'hFFFF);
    flush = 1'b0;

    // $0 normalisation and halt propagation
    wsel_i = 5'd0; wen_i = 1'b1; halt_i = 1'b1;
    step();
    chk("wsel0_wen", 64'(wen_o2), 64'd0);
    chk("wsel0_valid", 64'(valid_o2), 64'd1);
    chk("halt_set", 64'(halt_o2), 64'd1);
    chk("cap_keeps_bubble", 64'(bubble_cnt), 64'hFFFF);
    wsel_i = 5'd5; halt_i = 1'b0;
    step();
    chk("wsel5_wen", 64'(wen_o2), 64'd1);
    chk("halt_clear", 64'(halt_o2), 64'd0);

    // Writeback bypass
    rsel1_i = 5'd7; rsel2_i = 5'd7; rdat1_i = 32'h1; rdat2_i = 32'h2;
    wb_wen = 1'b1; wb_wsel = 5'd7; wb_wdat = 32'h55;
    step();
    chk("byp_rdat1", 64'(rdat1_o2), BYP ? 64'h55 : 64'h1);
    chk("byp_rdat2", 64'(rdat2_o2), BYP ? 64'h55 : 64'h2);
    rsel2_i = 5'd8;
    step();
    chk("byp_rdat1_only", 64'(rdat1_o2), BYP ? 64'h55 : 64'h1);
    chk("byp_rdat2_miss", 64'(rdat2_o2), 64'h2);
    wb_wsel = 5'd0; rsel1_i = 5'd0; rsel2_i = 5'd0;
    step();
    chk("byp_zero_rdat1", 64'(rdat1_o2), 64'h1);
    wb_wen = 1'b0; wb_wsel = 5'd7; rsel1_i = 5'd7;
    step();
    chk("byp_wen_off", 64'(rdat1_o2), 64'h1);

    // Reset during a held stall
    chk("pre_rst_valid", 64'(valid_o2), 64'd1);
    stall = 1'b1; RST = 1'b1;
    step();
    chk("rst_stall_valid", 64'(valid_o2), 64'd0);
    chk("rst_stall_wen", 64'(wen_o2), 64'd0);
    chk("rst_stall_rsel1", 64'(rsel1_o2), 64'd0);
    chk("rst_stall_bubble", 64'(bubble_cnt), 64'd0);
    RST = 1'b0; stall = 1'b0; instr_i = 32'hAABB_CCDD;
    step();
    chk("resume_instr", 64'(instr_o2), 64'hAABB_CCDD);
    chk("resume_valid", 64'(valid_o2), 64'd1);
    chk("resume_wen", 64'(wen_o2), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
